// File: rtl/seg7_pkg.sv
// Shared types, glyph constants and the nibble-to-glyph decoder for the
// 7-segment display controller. Glyphs are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        RENDER = 2'd2
    } state_t;

    localparam seg7_t SEG_BLANK = 7'b1111111;
    localparam seg7_t SEG_MINUS = 7'b0111111;

    function automatic seg7_t hex2seg(input logic [3:0] nib);
        seg7_t g;
        case (nib)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            4'hF:    g = 7'b0001110;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per clock.
// The first shift happens on the start edge, so busy covers DATA_W-1 further edges.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NDIGITS = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DATA_W-1:0]      bin,
    output logic                   busy,
    output logic [4*NDIGITS-1:0]   bcd,
    output logic                   ovf
);

    localparam int BW = 4 * NDIGITS;
    localparam int CW = $clog2(DATA_W);

    logic [DATA_W-1:0] sh_q, sh_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [BW-1:0]     adj_s;
    logic              ovf_q, ovf_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // Add-3 correction, then shift; a 1 leaving the top digit means the value did not fit
    always_comb begin
        sh_d  = sh_q;
        bcd_d = bcd_q;
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        adj_s = bcd_q;
        for (int k = 0; k < NDIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                adj_s[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end else begin
                adj_s[4*k +: 4] = bcd_q[4*k +: 4];
            end
        end
        if (start) begin
            bcd_d = {{(BW-1){1'b0}}, bin[DATA_W-1]};
            sh_d  = {bin[DATA_W-2:0], 1'b0};
            ovf_d = 1'b0;
            cnt_d = CW'(DATA_W - 1);
        end else if (cnt_q != '0) begin
            bcd_d = {adj_s[BW-2:0], sh_q[DATA_W-1]};
            sh_d  = {sh_q[DATA_W-2:0], 1'b0};
            ovf_d = ovf_q | adj_s[BW-1];
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Converter state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q  <= '0;
            bcd_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            bcd_q <= bcd_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/seg7_display_ctrl.sv
// Registered binary-to-7-segment display controller: decimal/hex, signed,
// leading-zero blanking, overflow indication and a one-deep pending write.
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NDIGITS    = 5,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   hex_mode,
    input  logic                   signed_mode,
    input  logic                   blank_lz,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [7*NDIGITS-1:0]   seg
);

    localparam int SW = 7 * NDIGITS;
    localparam int BW = 4 * NDIGITS;
    localparam int EW = DATA_W + BW;
    localparam logic [SW-1:0] SEG_RST = ACTIVE_LOW ? {SW{1'b1}} : {SW{1'b0}};

    state_t            state_q, state_d;
    logic              pend_vld_q, pend_vld_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic              pend_hex_q, pend_hex_d;
    logic              pend_sgn_q, pend_sgn_d;
    logic              pend_blz_q, pend_blz_d;
    logic [DATA_W-1:0] act_data_q, act_data_d;
    logic              act_hex_q, act_hex_d;
    logic              act_neg_q, act_neg_d;
    logic              act_blz_q, act_blz_d;
    logic [SW-1:0]     seg_q, seg_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] l_data_s, l_mag_s;
    logic              l_hex_s, l_sgn_s, l_blz_s, l_neg_s;
    logic              launch_s, conv_start_s;
    logic              conv_busy_s, conv_ovf_s;
    logic [BW-1:0]     conv_bcd_s;
    logic [EW-1:0]     hex_ext_s;
    logic [3:0]        digit_s [NDIGITS];
    int                msd_s, sign_pos_s;
    logic              frame_ovf_s;
    logic [SW-1:0]     render_s;

    // Launch source: a live write always wins over the pending slot
    always_comb begin
        if (wr_en) begin
            l_data_s = wr_data;
            l_hex_s  = hex_mode;
            l_sgn_s  = signed_mode;
            l_blz_s  = blank_lz;
        end else begin
            l_data_s = pend_data_q;
            l_hex_s  = pend_hex_q;
            l_sgn_s  = pend_sgn_q;
            l_blz_s  = pend_blz_q;
        end
        l_neg_s = l_sgn_s & l_data_s[DATA_W-1] & ~l_hex_s;
        l_mag_s = l_neg_s ? (~l_data_s + DATA_W'(1)) : l_data_s;
    end

    assign conv_start_s = launch_s & ~l_hex_s;

    bin2bcd_seq #(
        .DATA_W  (DATA_W),
        .NDIGITS (NDIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start_s),
        .bin   (l_mag_s),
        .busy  (conv_busy_s),
        .bcd   (conv_bcd_s),
        .ovf   (conv_ovf_s)
    );

    assign hex_ext_s = {{BW{1'b0}}, act_data_q};

    // Frame rendering: digit selection, blanking, sign placement and overflow
    always_comb begin
        render_s    = '0;
        msd_s       = 0;
        frame_ovf_s = act_hex_q ? (|(hex_ext_s >> BW)) : conv_ovf_s;
        for (int k = 0; k < NDIGITS; k++) begin
            digit_s[k] = act_hex_q ? hex_ext_s[4*k +: 4] : conv_bcd_s[4*k +: 4];
        end
        for (int k = 0; k < NDIGITS; k++) begin
            if (digit_s[k] != 4'd0) begin
                msd_s = k;
            end else begin
                msd_s = msd_s;
            end
        end
        sign_pos_s = act_blz_q ? (msd_s + 1) : (NDIGITS - 1);
        if (act_neg_q && (act_blz_q ? (msd_s == NDIGITS - 1)
                                    : (digit_s[NDIGITS-1] != 4'd0))) begin
            frame_ovf_s = 1'b1;
        end else begin
            frame_ovf_s = frame_ovf_s;
        end
        for (int k = 0; k < NDIGITS; k++) begin
            if (frame_ovf_s || (act_neg_q && (k == sign_pos_s))) begin
                render_s[7*k +: 7] = SEG_MINUS;
            end else if (act_blz_q && (k > msd_s)) begin
                render_s[7*k +: 7] = SEG_BLANK;
            end else begin
                render_s[7*k +: 7] = hex2seg(digit_s[k]);
            end
        end
    end

    // FSM, pending slot and output next-state
    always_comb begin
        state_d     = state_q;
        pend_vld_d  = pend_vld_q;
        pend_data_d = pend_data_q;
        pend_hex_d  = pend_hex_q;
        pend_sgn_d  = pend_sgn_q;
        pend_blz_d  = pend_blz_q;
        act_data_d  = act_data_q;
        act_hex_d   = act_hex_q;
        act_neg_d   = act_neg_q;
        act_blz_d   = act_blz_q;
        seg_d       = seg_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;
        launch_s    = 1'b0;
        case (state_q)
            IDLE: begin
                launch_s = wr_en;
            end
            CONV: begin
                if (wr_en) begin
                    pend_vld_d  = 1'b1;
                    pend_data_d = wr_data;
                    pend_hex_d  = hex_mode;
                    pend_sgn_d  = signed_mode;
                    pend_blz_d  = blank_lz;
                end else begin
                    pend_vld_d  = pend_vld_q;
                end
                state_d = conv_busy_s ? CONV : RENDER;
            end
            RENDER: begin
                seg_d  = ACTIVE_LOW ? render_s : ~render_s;
                ovf_d  = frame_ovf_s;
                done_d = 1'b1;
                if (wr_en || pend_vld_q) begin
                    launch_s   = 1'b1;
                    pend_vld_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (launch_s) begin
            state_d    = l_hex_s ? RENDER : CONV;
            act_data_d = l_data_s;
            act_hex_d  = l_hex_s;
            act_neg_d  = l_neg_s;
            act_blz_d  = l_blz_s;
        end else begin
            act_data_d = act_data_q;
        end
        busy_d = (state_d != IDLE);
    end

    // Controller registers; reset abandons any conversion and the pending write
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_vld_q  <= 1'b0;
            pend_data_q <= '0;
            pend_hex_q  <= 1'b0;
            pend_sgn_q  <= 1'b0;
            pend_blz_q  <= 1'b0;
            act_data_q  <= '0;
            act_hex_q   <= 1'b0;
            act_neg_q   <= 1'b0;
            act_blz_q   <= 1'b0;
            seg_q       <= SEG_RST;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
            pend_hex_q  <= pend_hex_d;
            pend_sgn_q  <= pend_sgn_d;
            pend_blz_q  <= pend_blz_d;
            act_data_q  <= act_data_d;
            act_hex_q   <= act_hex_d;
            act_neg_q   <= act_neg_d;
            act_blz_q   <= act_blz_d;
            seg_q       <= seg_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
        end
    end

    assign seg      = seg_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Self-checking bench for seg7_display_ctrl (DATA_W=32, NDIGITS=5, active-low).
module tb_seg7_display_ctrl;

    localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30, G4 = 7'h19;
    localparam logic [6:0] G5 = 7'h12, G7 = 7'h78, G9 = 7'h10, GA = 7'h08, GB = 7'h03;
    localparam logic [6:0] GE = 7'h06, GF = 7'h0E, BL = 7'h7F, MI = 7'h3F;
    localparam logic [34:0] ALLM = {MI, MI, MI, MI, MI};
    localparam int NV = 16;

    typedef struct {
        logic [31:0] data;
        logic        hex;
        logic        sgn;
        logic        blz;
        logic [34:0] seg;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [34:0] seg;
        logic        ovf;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = 32'd0;
    logic        hex_mode = 1'b0;
    logic        signed_mode = 1'b0;
    logic        blank_lz = 1'b0;
    logic        busy, done, overflow;
    logic [34:0] seg;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  n_done  = 0;
    sb_t sb_q[$];
    vec_t vecs[NV];

    seg7_display_ctrl #(
        .DATA_W     (32),
        .NDIGITS    (5),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .hex_mode    (hex_mode),
        .signed_mode (signed_mode),
        .blank_lz    (blank_lz),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .seg         (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest expected frame
    always @(negedge clk) begin
        if (!rst && done) begin
            sb_t e;
            n_done++;
            check("done_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("frame_seg", 64'(seg), 64'(e.seg));
                check("frame_ovf", 64'(overflow), 64'(e.ovf));
            end
        end
    end

    task automatic drive(input logic [31:0] d, input logic h, input logic s, input logic b);
        wr_en = 1'b1; wr_data = d; hex_mode = h; signed_mode = s; blank_lz = b;
    endtask

    task automatic push(input logic [34:0] es, input logic eo);
        sb_t e;
        e.seg = es; e.ovf = eo;
        sb_q.push_back(e);
    endtask

    task automatic write(input logic [31:0] d, input logic h, input logic s, input logic b,
                         input logic [34:0] es, input logic eo, input bit expect_frame);
        @(negedge clk);
        drive(d, h, s, b);
        if (expect_frame) push(es, eo);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int t = 0;
        while ((sb_q.size() != 0 || busy) && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (t >= 300) begin
            n_fail++;
            $display("FAIL %s: timeout, busy=%0b queued=%0d, expected idle", nm, busy, sb_q.size());
        end
    endtask

    // Called right after driving a write at a negedge; measures edges to done
    task automatic measure(input string nm, input int exp_lat);
        int lat = 0;
        int idle = 0;
        @(posedge clk);
        #1 wr_en = 1'b0;
        check({nm, "_busy_start"}, 64'(busy), 64'd1);
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (!done && !busy) idle++;
        end
        check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        check({nm, "_busy_gap"}, 64'(idle), 64'd0);
        check({nm, "_busy_end"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        vecs[0]  = '{32'd12345,    1'b0, 1'b0, 1'b0, {G1, G2, G3, G4, G5}, 1'b0};
        vecs[1]  = '{32'd42,       1'b0, 1'b0, 1'b1, {BL, BL, BL, G4, G2}, 1'b0};
        vecs[2]  = '{32'd42,       1'b0, 1'b0, 1'b0, {G0, G0, G0, G4, G2}, 1'b0};
        vecs[3]  = '{32'hFFFFFFF9, 1'b0, 1'b1, 1'b1, {BL, BL, BL, MI, G7}, 1'b0};
        vecs[4]  = '{32'hFFFFCFC7, 1'b0, 1'b1, 1'b1, ALLM, 1'b1};
        vecs[5]  = '{32'd7,        1'b0, 1'b0, 1'b1, {BL, BL, BL, BL, G7}, 1'b0};
        vecs[6]  = '{32'h80000000, 1'b0, 1'b1, 1'b1, ALLM, 1'b1};
        vecs[7]  = '{32'd100000,   1'b0, 1'b0, 1'b0, ALLM, 1'b1};
        vecs[8]  = '{32'h0000BEEF, 1'b1, 1'b0, 1'b0, {G0, GB, GE, GE, GF}, 1'b0};
        vecs[9]  = '{32'h00100000, 1'b1, 1'b0, 1'b0, ALLM, 1'b1};
        vecs[10] = '{32'd0,        1'b0, 1'b0, 1'b1, {BL, BL, BL, BL, G0}, 1'b0};
        vecs[11] = '{32'd99999,    1'b0, 1'b0, 1'b0, {G9, G9, G9, G9, G9}, 1'b0};
        vecs[12] = '{32'hFFFFFFF9, 1'b0, 1'b1, 1'b0, {MI, G0, G0, G0, G7}, 1'b0};
        vecs[13] = '{32'hFFFFFB2E, 1'b0, 1'b1, 1'b1, {MI, G1, G2, G3, G4}, 1'b0};
        vecs[14] = '{32'h000000A5, 1'b1, 1'b1, 1'b1, {BL, BL, BL, GA, G5}, 1'b0};
        vecs[15] = '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, ALLM, 1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_seg", 64'(seg), 64'h7FFFFFFFF);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        rst = 1'b0;

        @(negedge clk);
        drive(32'd12345, 1'b0, 1'b0, 1'b0);
        push({G1, G2, G3, G4, G5}, 1'b0);
        measure("dec", 33);
        wait_drain("dec_drain");

        @(negedge clk);
        drive(32'h0000BEEF, 1'b1, 1'b0, 1'b0);
        push({G0, GB, GE, GE, GF}, 1'b0);
        measure("hex", 1);
        wait_drain("hex_drain");

        for (int i = 0; i < NV; i++) begin
            write(vecs[i].data, vecs[i].hex, vecs[i].sgn, vecs[i].blz, vecs[i].seg, vecs[i].ovf, 1'b1);
            wait_drain("vec_drain");
        end

        // Pending slot: the newest write while busy replaces the older one
        snap = n_done;
        write(32'd1, 1'b0, 1'b0, 1'b1, {BL, BL, BL, BL, G1}, 1'b0, 1'b1);
        write(32'd2, 1'b0, 1'b0, 1'b1, {BL, BL, BL, BL, G2}, 1'b0, 1'b0);
        write(32'd3, 1'b0, 1'b0, 1'b1, {BL, BL, BL, BL, G3}, 1'b0, 1'b1);
        wait_drain("pend_drain");
        repeat (40) @(negedge clk);
        check("pend_done_count", 64'(n_done - snap), 64'd2);

        // A write in the RENDER cycle beats the pending slot, which is then dropped
        snap = n_done;
        @(negedge clk);
        drive(32'd5, 1'b0, 1'b0, 1'b1);
        push({BL, BL, BL, BL, G5}, 1'b0);
        @(posedge clk);
        #1 wr_en = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) drive(32'd6, 1'b0, 1'b0, 1'b1);
            else wr_en = 1'b0;
        end
        drive(32'd7, 1'b0, 1'b0, 1'b1);
        push({BL, BL, BL, BL, G7}, 1'b0);
        @(posedge clk);
        #1 wr_en = 1'b0;
        wait_drain("prio_drain");
        repeat (40) @(negedge clk);
        check("prio_done_count", 64'(n_done - snap), 64'd2);

        // Reset in the middle of a conversion blanks the display at once
        snap = n_done;
        write(32'd54321, 1'b0, 1'b0, 1'b0, {G5, G4, G3, G2, G1}, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_seg", 64'(seg), 64'h7FFFFFFFF);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_no_done", 64'(n_done - snap), 64'd0);
        check("midrst_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
